mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master to one-slave Wishbone-style arbiter sitting directly upstream of the single-port memory.
- Master 0 is instruction fetch; master 1 is load/store.
- Forwards one transaction at a time to the memory, routes the memory ack and read data back to the owning master, and arbitrates simultaneous requests round-robin.
- Includes a per-transaction timeout watchdog so a hung slave cannot deadlock the core.

Parameters:
- TIMEOUT, 16, cycles after slave acceptance with no ack before the transaction is force-terminated (range 4..255).
- ERR_DATA, 32'hFFFFFFFF, read data returned to the owner on a timeout termination.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_m0_stb, i_m1_stb  in  1  master request strobe
- i_m0_addr, i_m1_addr  in  32  byte address
- i_m0_data, i_m1_data  in  32  write data
- i_m0_we, i_m1_we  in  1  1 = write
- i_m0_sel, i_m1_sel  in  3  size code: 000 = byte sign-ext, 001 = half sign-ext, 010 = word, 100 = byte zero-ext, 101 = half zero-ext
- o_m0_data, o_m1_data  out  32  read data; valid only with ack, else 32'hFFFFFFFF
- o_m0_ack, o_m1_ack  out  1  one-cycle completion pulse
- o_m0_stall, o_m1_stall  out  1  request not accepted this cycle
- o_mem_stb, o_mem_we  out  1  slave strobe and write enable
- o_mem_addr, o_mem_data  out  32  slave address and write data
- o_mem_sel  out  3  slave size code
- i_mem_data  in  32  slave read data
- i_mem_ack, i_mem_stall  in  1  slave handshake
- o_timeout  out  1  one-cycle pulse when a transaction is force-terminated

Behaviour:
- States: S_IDLE, S_BUSY_M0, S_BUSY_M1. One outstanding transaction maximum.
- Registers: state, last_grant (1 bit), timeout counter (8 bit).
- Reset, applied in the same cycle i_reset is high:
  - state = S_IDLE, last_grant = 1, counter = 0.
  - While i_reset is high: both master stalls = 1, both acks = 0, o_mem_stb = 0, o_timeout = 0, master data = 32'hFFFFFFFF.
- Grant selection in S_IDLE (combinational):
  - Only one stb high: that master is granted.
  - Both high: grant the master != last_grant. After reset, m0 wins the first tie.
- S_IDLE forwarding:
  - o_mem_* = granted master's addr, data, we, sel, and stb.
  - Granted master's stall = i_mem_stall. The other master's stall = 1.
  - Accept condition: o_mem_stb && !i_mem_stall. On accept, go to S_BUSY_Mx, set last_grant = x, clear the counter.
- S_BUSY_Mx:
  - o_mem_stb = 0. Both master stalls = 1. Counter increments each cycle.
  - i_mem_ack high: o_mx_ack = 1 and o_mx_data = i_mem_data in the same cycle (combinational pass-through), then go to S_IDLE.
  - Counter reaches TIMEOUT - 1 with no ack: o_mx_ack = 1, o_mx_data = ERR_DATA, o_timeout = 1, go to S_IDLE.
- No new request is issued in the ack cycle. The slave latches requests only in its idle state, even though it drops stall during ack. Earliest back-to-back accept is the cycle after the ack.
- Latency: accept at T, slave ack at T+2, master ack at T+2, next accept at T+3. Minimum 3-cycle issue interval.
- i_mem_ack in S_IDLE (stale ack after reset or after a timeout) is ignored. No master ack is generated.
- The non-owning master never sees ack. Master data is 32'hFFFFFFFF whenever its ack is 0.
- Reset mid-transaction: return to S_IDLE next cycle and drop the transaction. The owner never receives an ack.
- Masters must hold stb, addr, data, we, sel stable while stalled. The arbiter does not register request fields.

Decomposition:
- Shared package mem_bus_pkg holds:
  - Size-code constants SEL_B, SEL_H, SEL_W, SEL_BU, SEL_HU.
  - Arbiter state encodings.
  - Master index constants M_IFETCH = 0, M_LSU = 1.
  - ERR_DATA default.
- One sub-module, rr_grant2: 2-request round-robin picker. Inputs: req[1:0] and last_grant. Outputs: grant one-hot and grant_valid. Purely combinational; last_grant is held in the parent.

Test Plan:
- m0 read, addr 0x0, sel 010, slave returns 0x00000013 at T+2 -> o_m0_ack = 1 at T+2, o_m0_data = 0x00000013; m1 ack stays 0, m1 data = 0xFFFFFFFF.
- m0 and m1 both strobe at the same cycle after reset -> m0 granted first. m1 stalled until the cycle after m0's ack, then granted. Accepts 3 cycles apart.
- Both masters continuously strobing for 4 transactions -> grant order m0, m1, m0, m1.
- m1 write, addr 0x103, data 0x0000BEEF, sel 001 -> o_mem_addr = 0x103, o_mem_data = 0x0000BEEF, o_mem_sel = 001 on the accept cycle; o_m1_ack at T+2.
- Slave never acks, TIMEOUT = 16 -> at T+16: o_m1_ack = 1, o_m1_data = 0xFFFFFFFF, o_timeout = 1. A later stray i_mem_ack in S_IDLE produces no ack.
- i_reset asserted at T+1 of an m0 read -> o_m0_ack never pulses. Slave ack at T+2 is ignored. A new m0 request is accepted after reset deasserts.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the instruction/data memory bus: size codes,
// arbiter state encodings, master indices and the request bundle type.
package mem_bus_pkg;

    // Size codes carried on *_sel
    localparam logic [2:0] SEL_B  = 3'b000;  // byte, sign-extended
    localparam logic [2:0] SEL_H  = 3'b001;  // half, sign-extended
    localparam logic [2:0] SEL_W  = 3'b010;  // word
    localparam logic [2:0] SEL_BU = 3'b100;  // byte, zero-extended
    localparam logic [2:0] SEL_HU = 3'b101;  // half, zero-extended

    // Arbiter states
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_M0 = 2'd1;
    localparam logic [1:0] S_BUSY_M1 = 2'd2;

    // Master indices
    localparam logic M_IFETCH = 1'b0;
    localparam logic M_LSU    = 1'b1;

    // Read data returned on a watchdog termination, and on any non-ack cycle
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [31:0] IDLE_DATA        = 32'hFFFF_FFFF;

    // One master's request fields, as forwarded to the slave
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [2:0]  sel;
    } mem_req_t;

endpackage

// File: rtl/rr_grant2.sv
// Two-request round-robin picker. Purely combinational; the caller holds
// last_grant and updates it when a grant is actually consumed.
module rr_grant2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_valid
);

    // On a tie, favour the requester that was not served last
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign grant_valid = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (ifetch, load/store) to one-slave Wishbone-style arbiter with a
// single outstanding transaction and a per-transaction ack watchdog.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_stb,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    input  logic        i_m0_we,
    input  logic [2:0]  i_m0_sel,
    input  logic        i_m1_stb,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    input  logic        i_m1_we,
    input  logic [2:0]  i_m1_sel,
    output logic [31:0] o_m0_data,
    output logic        o_m0_ack,
    output logic        o_m0_stall,
    output logic [31:0] o_m1_data,
    output logic        o_m1_ack,
    output logic        o_m1_stall,
    output logic        o_mem_stb,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_data,
    output logic [2:0]  o_mem_sel,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_ack,
    input  logic        i_mem_stall,
    output logic        o_timeout
);

    // Counter value seen in the last cycle a transaction may wait for its ack
    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  count_q, count_d;

    logic [1:0]  grant;
    logic        grant_valid;
    logic [31:0] done_data;
    mem_req_t    m0_req, m1_req, fwd_req;

    assign m0_req  = '{addr: i_m0_addr, data: i_m0_data, we: i_m0_we, sel: i_m0_sel};
    assign m1_req  = '{addr: i_m1_addr, data: i_m1_data, we: i_m1_we, sel: i_m1_sel};
    assign fwd_req = grant[1] ? m1_req : m0_req;

    rr_grant2 u_rr_grant2 (
        .req         ({i_m1_stb, i_m0_stb}),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Next-state logic plus all bus outputs; reset overrides the outputs last
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        done_data    = ERR_DATA;

        o_mem_stb  = 1'b0;
        o_mem_we   = 1'b0;
        o_mem_addr = '0;
        o_mem_data = '0;
        o_mem_sel  = '0;
        o_m0_stall = 1'b1;
        o_m1_stall = 1'b1;
        o_m0_ack   = 1'b0;
        o_m1_ack   = 1'b0;
        o_m0_data  = IDLE_DATA;
        o_m1_data  = IDLE_DATA;
        o_timeout  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    o_mem_stb  = 1'b1;
                    o_mem_we   = fwd_req.we;
                    o_mem_addr = fwd_req.addr;
                    o_mem_data = fwd_req.data;
                    o_mem_sel  = fwd_req.sel;
                    if (grant[1]) begin
                        o_m1_stall = i_mem_stall;
                    end else if (grant[0]) begin
                        o_m0_stall = i_mem_stall;
                    end
                    if (!i_mem_stall) begin
                        state_d      = grant[1] ? S_BUSY_M1 : S_BUSY_M0;
                        last_grant_d = grant[1] ? M_LSU : M_IFETCH;
                        count_d      = '0;
                    end
                end
            end

            S_BUSY_M0, S_BUSY_M1: begin
                count_d = count_q + 8'd1;
                // Ack wins over a watchdog expiry in the same cycle
                if (i_mem_ack || (count_q == COUNT_LAST)) begin
                    done_data = i_mem_ack ? i_mem_data : ERR_DATA;
                    o_timeout = !i_mem_ack;
                    if (state_q == S_BUSY_M1) begin
                        o_m1_ack  = 1'b1;
                        o_m1_data = done_data;
                    end else begin
                        o_m0_ack  = 1'b1;
                        o_m0_data = done_data;
                    end
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (i_reset) begin
            o_mem_stb  = 1'b0;
            o_m0_stall = 1'b1;
            o_m1_stall = 1'b1;
            o_m0_ack   = 1'b0;
            o_m1_ack   = 1'b0;
            o_m0_data  = IDLE_DATA;
            o_m1_data  = IDLE_DATA;
            o_timeout  = 1'b0;
        end
    end

    // State registers with synchronous reset; m0 wins the first tie
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= M_LSU;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then random traffic,
// with a bench-side slave and a transaction-level expectation of every ack.
module tb_mem_arbiter;
    import mem_bus_pkg::*;

    localparam int TO = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [2:0]  sel;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic        to;
        int          acc;
    } exp_t;

    logic        i_clk, i_reset;
    logic        i_m0_stb, i_m0_we, i_m1_stb, i_m1_we;
    logic [31:0] i_m0_addr, i_m0_data, i_m1_addr, i_m1_data;
    logic [2:0]  i_m0_sel, i_m1_sel;
    logic [31:0] o_m0_data, o_m1_data;
    logic        o_m0_ack, o_m0_stall, o_m1_ack, o_m1_stall;
    logic        o_mem_stb, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_data;
    logic [2:0]  o_mem_sel;
    logic [31:0] i_mem_data;
    logic        i_mem_ack, i_mem_stall;
    logic        o_timeout;

    mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(32'hFFFF_FFFF)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_m0_stb    (i_m0_stb),
        .i_m0_addr   (i_m0_addr),
        .i_m0_data   (i_m0_data),
        .i_m0_we     (i_m0_we),
        .i_m0_sel    (i_m0_sel),
        .i_m1_stb    (i_m1_stb),
        .i_m1_addr   (i_m1_addr),
        .i_m1_data   (i_m1_data),
        .i_m1_we     (i_m1_we),
        .i_m1_sel    (i_m1_sel),
        .o_m0_data   (o_m0_data),
        .o_m0_ack    (o_m0_ack),
        .o_m0_stall  (o_m0_stall),
        .o_m1_data   (o_m1_data),
        .o_m1_ack    (o_m1_ack),
        .o_m1_stall  (o_m1_stall),
        .o_mem_stb   (o_mem_stb),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_data  (o_mem_data),
        .o_mem_sel   (o_mem_sel),
        .i_mem_data  (i_mem_data),
        .i_mem_ack   (i_mem_ack),
        .i_mem_stall (i_mem_stall),
        .o_timeout   (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Slave's word for an address; address 0 holds 0x13 (a nop)
    function automatic logic [31:0] slave_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h1357_2468);
    endfunction

    // Shared bench state (each variable has a single writing process)
    req_t        mq [2][$];      // main: pending master requests
    int          rd [2];         // driver: next request index per master
    logic [1:0]  m_active;       // driver: master presenting a request
    req_t        m_req [2];      // driver: request being presented
    int          taken [2];      // monitor: accept count per master
    int          seen [2];       // driver: accepts already retired
    exp_t        expq [2][$];    // monitor: scoreboard
    logic        slv_busy, slv_hang;
    int          slv_acc;
    logic [31:0] slv_addr;
    int          last_served;
    int          last_acc_cyc;
    int          acc_count;
    int          cyc;
    int          stray_cyc = -1;
    logic        hang_mode = 1'b0;
    logic        rand_mode = 1'b0;

    // Master and slave drivers: update all DUT inputs 1 time unit after the edge
    initial begin
        logic ack_now;
        cyc = 0;
        m_active = '0;
        for (int x = 0; x < 2; x++) begin
            rd[x] = 0;
            seen[x] = 0;
            m_req[x] = '0;
        end
        {i_m0_stb, i_m0_we, i_m0_addr, i_m0_data, i_m0_sel} = '0;
        {i_m1_stb, i_m1_we, i_m1_addr, i_m1_data, i_m1_sel} = '0;
        i_mem_ack = 1'b0;
        i_mem_stall = 1'b0;
        i_mem_data = '0;
        forever begin
            @(posedge i_clk);
            cyc++;
            #1;
            for (int x = 0; x < 2; x++) begin
                if (taken[x] != seen[x]) begin
                    seen[x] = taken[x];
                    m_active[x] = 1'b0;
                end
                if (!m_active[x] && !i_reset && rd[x] < mq[x].size() &&
                    (!rand_mode || $urandom_range(0, 1) == 1)) begin
                    m_req[x] = mq[x][rd[x]];
                    rd[x]++;
                    m_active[x] = 1'b1;
                end
            end
            i_m0_stb = m_active[0];
            {i_m0_addr, i_m0_data, i_m0_we, i_m0_sel} = m_req[0];
            i_m1_stb = m_active[1];
            {i_m1_addr, i_m1_data, i_m1_we, i_m1_sel} = m_req[1];

            ack_now = slv_busy && !slv_hang && (cyc == slv_acc + 2);
            i_mem_ack = ack_now || (cyc == stray_cyc);
            i_mem_data = ack_now ? slave_word(slv_addr) : $urandom();
            i_mem_stall = slv_busy ? !ack_now : (rand_mode && $urandom_range(0, 3) == 0);
        end
    end

    initial begin
        slv_busy = 1'b0;
        slv_hang = 1'b0;
        slv_acc = 0;
        slv_addr = '0;
        last_served = 1;
        last_acc_cyc = -100;
        acc_count = 0;
        taken[0] = 0;
        taken[1] = 0;
    end

    // Monitor: scoreboard pops on acks, pushes on accepts, checks bus rules
    always @(negedge i_clk) begin
        logic [1:0]  acks, stalls;
        logic [31:0] mdat [2];
        logic        outstanding, accepted, want;
        int          g;
        exp_t        e;
        acks = {o_m1_ack, o_m0_ack};
        stalls = {o_m1_stall, o_m0_stall};
        mdat[0] = o_m0_data;
        mdat[1] = o_m1_data;

        if (slv_busy && ((!slv_hang && cyc == slv_acc + 2) || (slv_hang && cyc == slv_acc + TO)))
            slv_busy = 1'b0;

        if (i_reset) begin
            chk("reset_ctrl", {26'd0, stalls, acks, o_mem_stb, o_timeout}, 32'b11_0000);
            chk("reset_m0_data", o_m0_data, 32'hFFFF_FFFF);
            chk("reset_m1_data", o_m1_data, 32'hFFFF_FFFF);
            expq[0].delete();
            expq[1].delete();
            last_served = 1;
            last_acc_cyc = -100;
        end else begin
            outstanding = (expq[0].size() + expq[1].size()) != 0;
            if (outstanding)
                chk("busy_quiet", {29'd0, o_mem_stb, stalls}, 32'b011);

            for (int x = 0; x < 2; x++) begin
                if (acks[x]) begin
                    if (expq[x].size() == 0) begin
                        chk($sformatf("spurious_ack_m%0d", x), 32'd1, 32'd0);
                    end else begin
                        e = expq[x].pop_front();
                        chk($sformatf("ack_data_m%0d", x), mdat[x], e.data);
                        chk($sformatf("timeout_flag_m%0d", x), {31'd0, o_timeout}, {31'd0, e.to});
                        chk($sformatf("ack_latency_m%0d", x), cyc - e.acc, e.to ? TO : 2);
                    end
                end else begin
                    chk($sformatf("idle_data_m%0d", x), mdat[x], 32'hFFFF_FFFF);
                end
            end
            if (acks == 2'b00)
                chk("timeout_no_ack", {31'd0, o_timeout}, 32'd0);

            accepted = o_mem_stb && !i_mem_stall;
            if (!outstanding) begin
                want = (m_active != 2'b00) && !i_mem_stall;
                chk("accept_when_free", {31'd0, accepted}, {31'd0, want});
                if (!accepted)
                    chk("stall_not_accepted", {30'd0, stalls}, 32'b11);
            end

            if (accepted && !outstanding) begin
                if (m_active == 2'b11) g = 1 - last_served;
                else g = m_active[1] ? 1 : 0;
                chk("grant_stalls", {30'd0, stalls}, (g == 1) ? 32'b01 : 32'b10);
                chk("fwd_fields", {28'd0, o_mem_addr ^ o_mem_data, o_mem_we, o_mem_sel},
                    {28'd0, m_req[g].addr ^ m_req[g].data, m_req[g].we, m_req[g].sel});
                chk("fwd_addr", o_mem_addr, m_req[g].addr);
                chk("fwd_data", o_mem_data, m_req[g].data);
                chk("issue_gap", {31'd0, (cyc - last_acc_cyc) >= 3}, 32'd1);
                slv_hang = hang_mode || (rand_mode && $urandom_range(0, 19) == 0);
                e.data = slv_hang ? 32'hFFFF_FFFF : slave_word(m_req[g].addr);
                e.to = slv_hang;
                e.acc = cyc;
                expq[g].push_back(e);
                slv_busy = 1'b1;
                slv_acc = cyc;
                slv_addr = m_req[g].addr;
                taken[g]++;
                last_served = g;
                last_acc_cyc = cyc;
                acc_count++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic push(input int x, input logic [31:0] a, input logic [31:0] d,
                        input logic we, input logic [2:0] sel);
        req_t r;
        r.addr = a;
        r.data = d;
        r.we = we;
        r.sel = sel;
        mq[x].push_back(r);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((rd[0] < mq[0].size() || rd[1] < mq[1].size() || m_active != 2'b00 ||
                expq[0].size() != 0 || expq[1].size() != 0 || slv_busy) && n < max) begin
            @(posedge i_clk);
            n++;
        end
        if (n >= max) chk("wait_idle_budget", 32'd1, 32'd0);
        tick(1);
    endtask

    task automatic do_reset(input int n);
        i_reset = 1'b1;
        tick(n);
        i_reset = 1'b0;
    endtask

    initial begin
        logic [2:0] sels [5];
        int n0, guard;
        sels = '{SEL_B, SEL_H, SEL_W, SEL_BU, SEL_HU};
        i_reset = 1'b1;
        tick(3);
        i_reset = 1'b0;

        // Single m0 fetch from address 0
        push(0, 32'h0, 32'h0, 1'b0, SEL_W);
        wait_idle(50);

        // Tie right after reset: m0 first, then m1
        do_reset(2);
        push(0, 32'h40, 32'h0, 1'b0, SEL_W);
        push(1, 32'h80, 32'h0, 1'b0, SEL_W);
        wait_idle(50);

        // Continuous contention: m0, m1, m0, m1
        push(0, 32'h44, 32'h0, 1'b0, SEL_W);
        push(0, 32'h48, 32'h0, 1'b0, SEL_W);
        push(1, 32'h84, 32'h0, 1'b0, SEL_W);
        push(1, 32'h88, 32'h0, 1'b0, SEL_W);
        wait_idle(80);

        // m1 halfword write at an odd address
        push(1, 32'h103, 32'h0000_BEEF, 1'b1, SEL_H);
        wait_idle(50);

        // Hung slave, then a stray ack while idle
        hang_mode = 1'b1;
        push(1, 32'h200, 32'h0, 1'b0, SEL_W);
        wait_idle(100);
        hang_mode = 1'b0;
        stray_cyc = cyc + 2;
        tick(6);

        // Reset in the cycle after an m0 read is accepted
        n0 = acc_count;
        push(0, 32'h300, 32'h0, 1'b0, SEL_W);
        guard = 0;
        while (acc_count == n0 && guard < 50) begin
            @(negedge i_clk);
            guard++;
        end
        chk("reset_mid_accepted", {31'd0, acc_count != n0}, 32'd1);
        @(posedge i_clk);
        #1;
        do_reset(1);
        tick(5);
        push(0, 32'h304, 32'h0, 1'b0, SEL_W);
        wait_idle(50);

        // Random traffic with slave stalls and occasional hangs
        rand_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            push($urandom_range(0, 1), $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                 sels[$urandom_range(0, 4)]);
            tick($urandom_range(0, 3));
        end
        wait_idle(20000);
        rand_mode = 1'b0;
        chk("total_accepts_min", {31'd0, acc_count >= 210}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
